// File: rtl/ultra_pkg.sv
// Shared constants, state encoding and frame-byte helper for the ultrasonic
// range-report transmitter.
package ultra_pkg;

    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int         FRAME_BYTES = 5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    typedef struct packed {
        tx_state_t  state;
        logic [2:0] byte_idx;
        logic [2:0] bit_idx;
        logic       bcd_valid;
    } tx_dbg_t;

    // Frame layout: 'R', hundreds, tens, ones, CR.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [3:0] hund,
                                              input logic [3:0] tens,
                                              input logic [3:0] ones);
        case (idx)
            3'd0:    frame_byte = ASCII_R;
            3'd1:    frame_byte = ASCII_ZERO + {4'h0, hund};
            3'd2:    frame_byte = ASCII_ZERO + {4'h0, tens};
            3'd3:    frame_byte = ASCII_ZERO + {4'h0, ones};
            default: frame_byte = ASCII_CR;
        endcase
    endfunction

endpackage

// File: rtl/ultra_range_tx_if.sv
// Request/status bundle between a frame requester and the range transmitter.
interface ultra_range_tx_if;
    // start is a one-edge request: it is taken on a rising clk edge only while
    // busy=0, and range is captured on that same edge; requests while busy=1 are dropped.
    logic       start;
    logic [7:0] range;
    logic       busy;
    logic       done;
    logic       txd;

    modport master (output start, range, input busy, done, txd);
    modport slave  (input start, range, output busy, done, txd);
endinterface

// File: rtl/ultra_bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3),
// result valid 8 cycles after load.
module ultra_bcd8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] bin,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);

    logic [7:0]  bin_sh;
    logic [11:0] bcd;
    logic [2:0]  cnt;
    logic        run;
    logic [3:0]  tens_adj;
    logic [3:0]  ones_adj;
    logic [11:0] bcd_n;

    // Hundreds can never exceed 2 for an 8-bit input, so it never needs the add-3 step.
    always_comb begin
        tens_adj = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        ones_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        bcd_n    = {bcd[10:8], tens_adj, ones_adj, bin_sh[7]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_sh <= '0;
            bcd    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            valid  <= 1'b0;
        end else if (load) begin
            bin_sh <= bin;
            bcd    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
            valid  <= 1'b0;
        end else if (run) begin
            bcd    <= bcd_n;
            bin_sh <= {bin_sh[6:0], 1'b0};
            cnt    <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                run   <= 1'b0;
                valid <= 1'b1;
            end
        end
    end

    assign hund = bcd[11:8];
    assign tens = bcd[7:4];
    assign ones = bcd[3:0];

endmodule

// File: rtl/ultra_range_tx.sv
// UART 8N1 transmitter sending "R<hundreds><tens><ones>\r" for an 8-bit range,
// emulating the ultrasonic sensor output.
module ultra_range_tx
    import ultra_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic             clk,
    input  logic             reset,
    ultra_range_tx_if.slave  tx,
    output tx_dbg_t          dbg
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BYTE = 3'(FRAME_BYTES - 1);

    tx_state_t     state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [2:0]    byte_idx, byte_n, next_byte;
    logic [7:0]    shift_q, shift_n;
    logic          txd_q, txd_n;
    logic          done_q, done_n;
    logic          bcd_load, bcd_valid, baud_last;
    logic [3:0]    hund, tens, ones;

    ultra_bcd8 u_bcd (
        .clk   (clk),
        .reset (reset),
        .load  (bcd_load),
        .bin   (tx.range),
        .hund  (hund),
        .tens  (tens),
        .ones  (ones),
        .valid (bcd_valid)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign next_byte = byte_idx + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            shift_q  <= shift_n;
            txd_q    <= txd_n;
            done_q   <= done_n;
        end
    end

    // txd_n is the line level for the bit that begins on the next edge.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        byte_n   = byte_idx;
        shift_n  = shift_q;
        txd_n    = txd_q;
        done_n   = 1'b0;
        bcd_load = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (tx.start) begin
                    state_n  = START;
                    baud_n   = '0;
                    bit_n    = '0;
                    byte_n   = '0;
                    shift_n  = ASCII_R;
                    txd_n    = 1'b0;
                    bcd_load = 1'b1;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    txd_n   = shift_q[0];
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift_q[7:1]};
                        txd_n   = shift_q[1];
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        txd_n   = 1'b1;
                    end else begin
                        state_n = START;
                        byte_n  = next_byte;
                        shift_n = frame_byte(next_byte, hund, tens, ones);
                        txd_n   = 1'b0;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx.busy = (state != IDLE);
    assign tx.done = done_q;
    assign tx.txd  = txd_q;

    assign dbg = '{state: state, byte_idx: byte_idx, bit_idx: bit_idx, bcd_valid: bcd_valid};

endmodule

// File: tb/tb_ultra_range_tx.sv
// Directed bench for ultra_range_tx with CLKS_PER_BIT=4: UART monitor,
// byte scoreboard, busy/done timing and line-waveform checks.
module tb_ultra_range_tx;
    import ultra_pkg::*;

    localparam int C = 4;

    logic clk = 1'b0;
    logic reset;
    tx_dbg_t dbg;

    always #5 clk = ~clk;

    ultra_range_tx_if bus ();

    ultra_range_tx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .tx    (bus),
        .dbg   (dbg)
    );

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int checks = 0;
    int errors = 0;

    logic trace[0:255];
    int   busy_cnt, done_cnt, done_idx, overlap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART monitor: detect start bit on a negedge, then sample every C cycles.
    initial begin : uart_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus.txd === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = bus.txd;
                end
                repeat (C) @(negedge clk);
                check("stop_bit", bus.txd, 1);
                rx_q.push_back(b);
            end
        end
    end

    task automatic push_frame(input logic [7:0] b0, b1, b2, b3, b4);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
        exp_q.push_back(b3); exp_q.push_back(b4);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        rx_q.delete();
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [7:0] r);
        bus.start = 1'b1;
        bus.range = r;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, bus.done, 1);
    endtask

    task automatic capture(input int n);
        busy_cnt = 0; done_cnt = 0; done_idx = -1; overlap = 0;
        for (int i = 0; i < n; i++) begin
            trace[i] = bus.txd;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_idx = i;
            end
            if (bus.busy && bus.done) overlap++;
            @(negedge clk);
        end
    endtask

    // Expected line level for "R012\r": start 0, 8 data LSB first, stop 1, 4 cycles each.
    task automatic check_trace();
        logic [7:0] f[5];
        int k, mism;
        logic e;
        f[0] = 8'h52; f[1] = 8'h30; f[2] = 8'h31; f[3] = 8'h32; f[4] = 8'h0D;
        mism = 0;
        for (int i = 0; i < 200; i++) begin
            k = (i % 40) / 4;
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = f[i / 40][k - 1];
            if (trace[i] !== e) mism++;
        end
        check("t6_bit_timing_mismatches", mism, 0);
        check("t6_first_cycle_low", trace[0], 0);
        check("t6_idle_after_frame", trace[200], 1);
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        tx_dbg_t rst_exp;
        int b;
        rst_exp = '{state: IDLE, byte_idx: 3'd0, bit_idx: 3'd0, bcd_valid: 1'b0};
        bus.start = 1'b0;
        bus.range = 8'd0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_txd", bus.txd, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbg", dbg, rst_exp);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1 + 6: range 12, busy span, single done, bit timing
        push_frame(8'h52, 8'h30, 8'h31, 8'h32, 8'h0D);
        send(8'd12);
        capture(206);
        check("t1_busy_cycles", busy_cnt, 200);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_done_index", done_idx, 200);
        check("t1_busy_done_overlap", overlap, 0);
        check_trace();
        check_frame("t1");

        // 2: boundary ranges
        push_frame(8'h52, 8'h30, 8'h30, 8'h30, 8'h0D);
        send(8'd0);
        wait_done("t2a", 300);
        repeat (2) @(negedge clk);
        check_frame("t2a");
        push_frame(8'h52, 8'h32, 8'h35, 8'h35, 8'h0D);
        send(8'd255);
        wait_done("t2b", 300);
        repeat (2) @(negedge clk);
        check_frame("t2b");

        // 3: start while busy ignored
        push_frame(8'h52, 8'h30, 8'h33, 8'h34, 8'h0D);
        send(8'd34);
        repeat (90) @(negedge clk);
        check("t3_busy_at_pulse", bus.busy, 1);
        send(8'd99);
        wait_done("t3", 300);
        b = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.busy) b++;
        end
        check_frame("t3");
        check("t3_no_second_frame_busy", b, 0);

        // 4: start held high, back-to-back frames with one idle cycle
        push_frame(8'h52, 8'h31, 8'h32, 8'h33, 8'h0D);
        push_frame(8'h52, 8'h30, 8'h34, 8'h35, 8'h0D);
        bus.start = 1'b1;
        bus.range = 8'd123;
        @(negedge clk);
        bus.range = 8'd45;
        wait_done("t4a", 300);
        check("t4_gap_txd", bus.txd, 1);
        check("t4_gap_busy", bus.busy, 0);
        @(negedge clk);
        check("t4_restart_txd", bus.txd, 0);
        check("t4_restart_busy", bus.busy, 1);
        bus.start = 1'b0;
        wait_done("t4b", 300);
        repeat (2) @(negedge clk);
        check_frame("t4");

        // 5: asynchronous reset mid-frame, then clean frame
        send(8'd50);
        repeat (95) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("t5_async_txd", bus.txd, 1);
        check("t5_async_busy", bus.busy, 0);
        check("t5_async_state", dbg.state, IDLE);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12 * C) @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        push_frame(8'h52, 8'h30, 8'h30, 8'h37, 8'h0D);
        send(8'd7);
        wait_done("t5", 300);
        repeat (2) @(negedge clk);
        check_frame("t5");
        check("t5_idle_state", dbg.state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
